// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the scratchpad memory responder.
package mem_pkg;

    localparam int WORD_W         = 64;
    localparam int ADDR_W         = 64;
    localparam int RD_LATENCY_MAX = 4;

    // Returned for any read that cannot be served from the array.
    localparam logic [WORD_W-1:0] POISON = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Physical memory port between the arbiter (master) and the responder (slave).
interface mem_responder_if;
    import mem_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_valid;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_valid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_valid, mem_rdata
    );

endinterface

// File: rtl/mem_responder_rd_pipe.sv
// Fixed-depth valid/data shift register carrying read responses.
// Asynchronous clear drops every in-flight response at once.
module mem_rd_pipe #(
    parameter int STAGES = 2,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);

    logic [STAGES-1:0] vld_p;
    logic [DATA_W-1:0] data_p [STAGES];

    // Shift valid and data one stage per cycle; entry stage captures the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_p[i] <= '0;
            end
        end else begin
            vld_p[0]  <= in_vld;
            data_p[0] <= in_data;
            for (int i = 1; i < STAGES; i++) begin
                vld_p[i]  <= vld_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end
    end

    assign out_vld  = vld_p[STAGES-1];
    assign out_data = data_p[STAGES-1];

endmodule

// File: rtl/mem_responder.sv
// Word-organised scratchpad serving the arbiter's memory port: single request
// per cycle, immediate write commit, fixed-latency reads, post-reset clear
// sweep, and sticky error flags that never stall the initiator.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_responder_if.slave       bus,
    output logic                 init_busy,
    output logic                 err_oor,
    output logic                 err_misalign,
    output logic                 err_init,
    input  logic                 err_clr,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("mem_responder: RD_LATENCY must be within 1..%0d", RD_LATENCY_MAX);
    end

    state_e                state_q;
    state_e                state_d;
    logic [DEPTH_LOG2-1:0] init_idx_q;
    logic [WORD_W-1:0]     mem [DEPTH];

    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  in_range;
    logic                  misalign;
    logic                  in_init;
    logic                  rd_req;
    logic                  wr_req;
    logic                  wr_commit;
    logic                  rd_accept;
    logic                  set_oor;
    logic                  set_mis;
    logic                  set_init;
    logic [WORD_W-1:0]     rd_data;

    // Address decode and request classification.
    always_comb begin
        word_idx  = bus.mem_addr[DEPTH_LOG2+2:3];
        in_range  = (bus.mem_addr[ADDR_W-1:DEPTH_LOG2+3] == '0);
        misalign  = |bus.mem_addr[2:0];
        in_init   = (state_q == S_INIT);
        rd_req    = bus.mem_req & ~bus.mem_we;
        wr_req    = bus.mem_req &  bus.mem_we;
        wr_commit = wr_req & ~in_init & in_range;
        rd_accept = rd_req & ~in_init;
        set_oor   = bus.mem_req & ~in_init & ~in_range;
        set_mis   = bus.mem_req & misalign;
        set_init  = bus.mem_req & in_init;
        // Reads during the sweep or beyond the array still answer, with POISON.
        rd_data   = (in_init || !in_range) ? POISON : mem[word_idx];
    end

    // Next-state logic: the sweep ends on the cycle that clears the last word.
    always_comb begin
        state_d   = state_q;
        init_busy = 1'b0;
        case (state_q)
            S_INIT: begin
                init_busy = 1'b1;
                if (&init_idx_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // State register and sweep pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (in_init) begin
                init_idx_q <= init_idx_q + 1'b1;
            end
        end
    end

    // Storage array: cleared by the sweep, otherwise written by in-range writes.
    always_ff @(posedge clk) begin
        if (in_init) begin
            mem[init_idx_q] <= '0;
        end else if (wr_commit) begin
            mem[word_idx] <= bus.mem_wdata;
        end
    end

    // Sticky error flags; a new event on the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_oor      <= 1'b0;
            err_misalign <= 1'b0;
            err_init     <= 1'b0;
        end else begin
            err_oor      <= set_oor  | (err_oor      & ~err_clr);
            err_misalign <= set_mis  | (err_misalign & ~err_clr);
            err_init     <= set_init | (err_init     & ~err_clr);
        end
    end

    // Access counters, wrapping modulo 2**32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_accept) begin
                rd_count <= rd_count + 32'd1;
            end
            if (wr_commit) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end

    mem_rd_pipe #(
        .STAGES (RD_LATENCY),
        .DATA_W (WORD_W)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (rd_req),
        .in_data  (rd_data),
        .out_vld  (bus.mem_valid),
        .out_data (bus.mem_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: DUT A (DEPTH_LOG2=4, RD_LATENCY=2) carries the main
// traffic; DUT B (DEPTH_LOG2=4, RD_LATENCY=3) exercises reset during a read.
module tb_mem_responder;

    localparam logic [63:0] POISON_C = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam int LAT_A = 2;

    logic clk;
    logic rst_a_n, rst_b_n;
    logic err_clr_a, err_clr_b;
    logic init_busy_a, err_oor_a, err_mis_a, err_init_a;
    logic init_busy_b, err_oor_b, err_mis_b, err_init_b;
    logic [31:0] rd_count_a, wr_count_a, rd_count_b, wr_count_b;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.DEPTH_LOG2(4), .RD_LATENCY(LAT_A)) dut_a (
        .clk          (clk),
        .rst_n        (rst_a_n),
        .bus          (bus_a),
        .init_busy    (init_busy_a),
        .err_oor      (err_oor_a),
        .err_misalign (err_mis_a),
        .err_init     (err_init_a),
        .err_clr      (err_clr_a),
        .rd_count     (rd_count_a),
        .wr_count     (wr_count_a)
    );

    mem_responder #(.DEPTH_LOG2(4), .RD_LATENCY(3)) dut_b (
        .clk          (clk),
        .rst_n        (rst_b_n),
        .bus          (bus_b),
        .init_busy    (init_busy_b),
        .err_oor      (err_oor_b),
        .err_misalign (err_mis_b),
        .err_init     (err_init_b),
        .err_clr      (err_clr_b),
        .rd_count     (rd_count_b),
        .wr_count     (wr_count_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int b_valid_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        int          due;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_oor;
        logic        exp_mis;
    } vec_t;
    vec_t vecs[$];

    int rd_exp = 0;
    int wr_exp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add_vec(input logic we, input logic [63:0] addr,
                                    input logic [63:0] wdata, input logic [63:0] exp_rdata,
                                    input logic exp_oor, input logic exp_mis);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_oor = exp_oor; v.exp_mis = exp_mis;
        vecs.push_back(v);
    endfunction

    // Scoreboard for DUT A: every response must match the oldest expected read and its cycle.
    always @(negedge clk) begin
        if (bus_a.mem_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid_a: got data %h with no read outstanding", bus_a.mem_rdata);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("rdata_a", bus_a.mem_rdata, e.data);
                chk("rd_latency_a", 64'(cyc), 64'(e.due));
            end
        end
        if (bus_b.mem_valid === 1'b1) b_valid_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive_a(input logic req, input logic we, input logic [63:0] addr,
                           input logic [63:0] wdata);
        bus_a.mem_req   = req;
        bus_a.mem_we    = we;
        bus_a.mem_addr  = addr;
        bus_a.mem_wdata = wdata;
    endtask

    task automatic read_a(input logic [63:0] addr, input logic [63:0] exp);
        sb_t e;
        drive_a(1'b1, 1'b0, addr, 64'd0);
        e.data = exp;
        e.due  = cyc + LAT_A;
        sb.push_back(e);
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_a", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int n;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        err_clr_a = 1'b0; err_clr_b = 1'b0;
        drive_a(1'b0, 1'b0, 64'd0, 64'd0);
        bus_b.mem_req = 1'b0; bus_b.mem_we = 1'b0;
        bus_b.mem_addr = 64'd0; bus_b.mem_wdata = 64'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_init_busy", 64'(init_busy_a), 64'd1);
        chk("rst_valid", 64'(bus_a.mem_valid), 64'd0);
        chk("rst_rdata", bus_a.mem_rdata, 64'd0);
        chk("rst_flags", {61'd0, err_oor_a, err_mis_a, err_init_a}, 64'd0);
        chk("rst_counts", {rd_count_a, wr_count_a}, 64'd0);

        // Release reset; read and write during the sweep, measure sweep length
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        read_a(64'h40, POISON_C);
        n = 0;
        while (init_busy_a && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) drive_a(1'b1, 1'b1, 64'h08, 64'hAAAA_AAAA_AAAA_AAAA);
            if (n == 2) drive_a(1'b0, 1'b0, 64'd0, 64'd0);
        end
        chk("init_cycles", 64'(n), 64'd16);
        chk("err_init_set", 64'(err_init_a), 64'd1);
        chk("init_no_count", {rd_count_a, wr_count_a}, 64'd0);
        drain_a();

        err_clr_a = 1'b1;
        @(negedge clk);
        err_clr_a = 1'b0;
        chk("err_init_clr", 64'(err_init_a), 64'd0);

        // Write then read-after-write on the next cycle
        drive_a(1'b1, 1'b1, 64'h18, 64'h1122_3344_5566_7788);
        @(negedge clk);
        read_a(64'h18, 64'h1122_3344_5566_7788);
        @(negedge clk);
        drive_a(1'b0, 1'b0, 64'd0, 64'd0);
        drain_a();
        chk("raw_wr_count", 64'(wr_count_a), 64'd1);
        chk("raw_rd_count", 64'(rd_count_a), 64'd1);
        rd_exp = 1; wr_exp = 1;

        // Table-driven back-to-back traffic
        add_vec(1'b0, 64'h40, 64'd0, 64'd0, 1'b0, 1'b0);
        add_vec(1'b0, 64'h08, 64'd0, 64'd0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) add_vec(1'b1, 64'(k * 8), 64'(k), 64'd0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) add_vec(1'b0, 64'(k * 8), 64'd0, 64'(k), 1'b0, 1'b0);
        add_vec(1'b0, 64'h1B,   64'd0, 64'd3,    1'b0, 1'b1);
        add_vec(1'b0, 64'h1000, 64'd0, POISON_C, 1'b1, 1'b1);
        add_vec(1'b1, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1);
        add_vec(1'b0, 64'h00,   64'd0, 64'd0,    1'b1, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].we) begin
                drive_a(1'b1, 1'b1, vecs[i].addr, vecs[i].wdata);
                if (vecs[i].addr[63:7] == '0) wr_exp++;
            end else begin
                read_a(vecs[i].addr, vecs[i].exp_rdata);
                rd_exp++;
            end
            @(negedge clk);
            chk($sformatf("vec%0d_err_oor", i), 64'(err_oor_a), 64'(vecs[i].exp_oor));
            chk($sformatf("vec%0d_err_mis", i), 64'(err_mis_a), 64'(vecs[i].exp_mis));
            chk($sformatf("vec%0d_rd_count", i), 64'(rd_count_a), 64'(rd_exp));
            chk($sformatf("vec%0d_wr_count", i), 64'(wr_count_a), 64'(wr_exp));
        end
        drive_a(1'b0, 1'b0, 64'd0, 64'd0);
        drain_a();

        // Clear coinciding with a new out-of-range access: set wins for err_oor
        err_clr_a = 1'b1;
        read_a(64'h1000, POISON_C);
        @(negedge clk);
        err_clr_a = 1'b0;
        drive_a(1'b0, 1'b0, 64'd0, 64'd0);
        chk("clr_vs_set_oor", 64'(err_oor_a), 64'd1);
        chk("clr_mis", 64'(err_mis_a), 64'd0);
        chk("clr_rd_count", 64'(rd_count_a), 64'(rd_exp + 1));
        err_clr_a = 1'b1;
        @(negedge clk);
        err_clr_a = 1'b0;
        chk("clr_oor", 64'(err_oor_a), 64'd0);
        drain_a();

        // Reset one cycle after a read on the RD_LATENCY=3 instance
        chk("b_running", 64'(init_busy_b), 64'd0);
        bus_b.mem_req = 1'b1; bus_b.mem_we = 1'b0; bus_b.mem_addr = 64'h00;
        @(negedge clk);
        bus_b.mem_req = 1'b0;
        rst_b_n = 1'b0;
        #1;
        chk("b_rst_valid", 64'(bus_b.mem_valid), 64'd0);
        chk("b_rst_init_busy", 64'(init_busy_b), 64'd1);
        chk("b_rst_rd_count", 64'(rd_count_b), 64'd0);
        @(negedge clk);
        rst_b_n = 1'b1;
        n = 0;
        while (init_busy_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b_reinit_cycles", 64'(n), 64'd16);
        repeat (4) @(negedge clk);
        chk("b_no_valid", 64'(b_valid_seen), 64'd0);
        chk("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Single-port, word-organised scratchpad memory serving the physical memory port driven by `mem_arbiter`. It accepts one request per cycle and commits writes immediately. It returns read data through a fixed-latency pipeline and clears its contents with a post-reset init sweep. It flags out-of-range and misaligned accesses without ever stalling the initiator.

## Interface
Parameters:
- `DEPTH_LOG2`, 10: number of 64-bit words is 2**DEPTH_LOG2.
- `RD_LATENCY`, 2: cycles from read acceptance to `mem_valid`. Legal range 1..4; an illegal value is an elaboration error.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `mem_req`  in  1  request strobe, one cycle per request.
- `mem_we`  in  1  1 = write, 0 = read; qualified by `mem_req`.
- `mem_addr`  in  64  byte address.
- `mem_wdata`  in  64  write data.
- `mem_valid`  out  1  read-response strobe, one cycle per accepted read.
- `mem_rdata`  out  64  read data; valid only while `mem_valid`=1.
- `init_busy`  out  1  high during the post-reset clear sweep.
- `err_oor`  out  1  sticky flag: access beyond DEPTH.
- `err_misalign`  out  1  sticky flag: `mem_addr[2:0]` != 0.
- `err_init`  out  1  sticky flag: request arrived while `init_busy`=1.
- `err_clr`  in  1  synchronous clear of all three sticky flags.
- `rd_count`  out  32  accepted reads, wraps modulo 2**32.
- `wr_count`  out  32  committed writes, wraps modulo 2**32.

## Operation
- **Address decode.**
  - Word index = `mem_addr[DEPTH_LOG2+2:3]`.
  - In range means `mem_addr[63:DEPTH_LOG2+3]` == 0.
  - `mem_addr[2:0]` is ignored for indexing; a non-zero value sets `err_misalign`.
- **States.** Two states: INIT and RUN.
  - Reset enters INIT. INIT writes 0 to word k on cycle k, for k = 0..2**DEPTH_LOG2-1.
  - After the last word is written, the block moves to RUN and deasserts `init_busy`.
  - INIT never re-enters except via reset.
- **Requests during INIT.**
  - Writes are dropped.
  - Reads still produce a `mem_valid` carrying `POISON` (64'hDEAD_BEEF_DEAD_BEEF), so the arbiter's blocking read cannot hang.
  - `err_init` is set. Counters do not change.
- **Write in RUN.**
  - In range: the word is stored at the clock edge and `wr_count` increments.
  - Out of range: the write is dropped, `err_oor` is set, and `wr_count` is not incremented.
- **Read in RUN.**
  - `rd_count` increments.
  - In range: the stored word enters the response pipeline.
  - Out of range: `POISON` enters the pipeline and `err_oor` is set.
- **Writes never produce `mem_valid`.**
- **Simultaneous `err_clr` and a new error event:** the set wins.

## Timing
- **Reset values.** All outputs are 0, except `init_busy`=1 from reset assertion onward. Counters and flags are 0.
- **Read latency.** A read sampled at edge T asserts `mem_valid` high for exactly one cycle after edge T+RD_LATENCY-1. In other words, it is visible in the cycle following the RD_LATENCY-th edge counting from T.
- **Throughput.** Back-to-back reads on every cycle are supported, with one response per cycle and order preserved.
- **Read-after-write.** A write at edge T followed by a read of the same index at edge T+1 returns the new data.
- **Reset mid-operation.** All in-flight reads are discarded and `mem_valid` drops immediately. Contents are lost and the INIT sweep restarts.
- **INIT duration.** INIT lasts exactly 2**DEPTH_LOG2 cycles after `rst_n` deasserts. `init_busy` falls on the edge that writes the last word.

## Structure
- Package `mem_pkg` holds: `WORD_W`=64, `POISON`, `RD_LATENCY_MAX`=4, and the state enum {`S_INIT`, `S_RUN`}.
- Sub-module `mem_rd_pipe` is a RD_LATENCY-deep valid/data shift register with asynchronous clear. The top level holds the array, INIT counter, decode, flags and counters.

## Test plan
- **Reset and init, DEPTH_LOG2=4.** Release `rst_n`; check `init_busy` is high for exactly 16 cycles. Then read addr 0x40 and check `mem_rdata`=0 with `mem_valid` at RD_LATENCY.
- **Write/read and read-after-write.** Write 0x1122334455667788 to 0x18, then read 0x18 on the next cycle. Expect that value after RD_LATENCY cycles, and `wr_count`=1, `rd_count`=1.
- **Streaming reads.** Issue 8 consecutive reads to 0x00..0x38, each word preloaded with its index. Expect 8 consecutive `mem_valid` cycles returning data 0..7 in order.
- **Out of range.** Read 0x1000 with DEPTH_LOG2=4; expect `POISON` and `err_oor`=1. Write 0x1000; expect no memory change and `wr_count` unchanged. Assert `err_clr` in the same cycle as a new out-of-range access; expect `err_oor` stays 1.
- **Misaligned and during-init access.** Read 0x1B; expect the data of word 3 and `err_misalign`=1. Read during INIT; expect `POISON` and `err_init`=1.
- **Reset mid-read, RD_LATENCY=3.** Assert `rst_n`=0 one cycle after a read; expect no `mem_valid` ever appears for that read, and INIT restarts.
